usb_pd_pll_ctrl: RTL and testbench

//  Sequences the 50 MHz-in / 30 MHz-out USB-PD PLL: pulses PLL reset, waits for extlock with

---
 rtl/usb_pd_pll_pkg.sv | 23 ++
 rtl/usb_pd_sync2.sv | 25 ++
 rtl/usb_pd_pll_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_usb_pd_pll_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pd_pll_pkg.sv
// Shared types and constants for the USB-PD PLL sequencer.
//   pll_state_t : sequencer state encoding. It is exposed on the top-level
//                 'state' debug port, so the numeric values are fixed.
//   LOST_CNT_W  : width of the saturating lock-loss event counter.
//   cnt_w()     : counter width for a counter that runs 0..n-1 (never below 1 bit).
package usb_pd_pll_pkg;

  localparam int STATE_W    = 3;
  localparam int LOST_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_pd_sync2.sv
// Generic two-flop synchroniser for a single asynchronous level.
//   clk   : destination clock
//   reset : synchronous active-high reset; clears both stages
//   d     : asynchronous input level
//   q     : input level resynchronised to clk, two cycles of latency
module usb_pd_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usb_pd_pll_ctrl.sv
// USB-PD PLL sequencer (50 MHz in, 30 MHz out). The block pulses the PLL
// reset, waits for lock with a timeout and a bounded number of retries, then
// qualifies lock for LOCK_STABLE cycles before it releases the system reset.
// While in RUN it watches lock and re-sequences the PLL if lock is lost.
// Ports:
//   refclk    : 50 MHz reference clock, the only clock of this block
//   reset     : synchronous active-high block reset
//   extlock   : PLL lock indication, asynchronous to refclk
//   restart   : single-cycle request that restarts the sequence from PLL_RST.
//               It is sampled on every refclk edge, needs no acknowledge, and
//               wins over any lock or timeout event in the same cycle.
//   pll_rst   : PLL reset pin, active-high
//   sys_rst   : downstream system reset, active-high
//   pll_ready : high only in RUN
//   fault     : high only in FAULT
//   lock_loss : one-cycle pulse when lock drops while in RUN
//   state     : current sequencer state (debug)
//   lost_cnt  : saturating count of lock_loss events
module usb_pd_pll_ctrl
  import usb_pd_pll_pkg::*;
#(
  parameter int RST_CYCLES   = 500,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 3
) (
  input  logic                  refclk,
  input  logic                  reset,
  input  logic                  extlock,
  input  logic                  restart,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  pll_ready,
  output logic                  fault,
  output logic                  lock_loss,
  output logic [STATE_W-1:0]    state,
  output logic [LOST_CNT_W-1:0] lost_cnt
);

  localparam int RST_W = cnt_w(RST_CYCLES);
  localparam int TMO_W = cnt_w(LOCK_TIMEOUT);
  localparam int STB_W = cnt_w(LOCK_STABLE);
  localparam int RTY_W = cnt_w(MAX_RETRY + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  logic lock_s;

  pll_state_t            state_q, state_n;
  logic [RST_W-1:0]      rst_cnt, rst_cnt_n;
  logic [TMO_W-1:0]      tmo_cnt, tmo_cnt_n;
  logic [STB_W-1:0]      stb_cnt, stb_cnt_n;
  logic [RTY_W-1:0]      retry_cnt, retry_n;
  logic [LOST_CNT_W-1:0] lost_n;
  logic                  loss_n;
  logic                  timeout;
  logic                  pll_rst_n, sys_rst_n, ready_n, fault_n;

  usb_pd_sync2 u_lock_sync (
    .clk   (refclk),
    .reset (reset),
    .d     (extlock),
    .q     (lock_s)
  );

  // The lock timeout spans WAIT_LOCK and STABLE together: a PLL that keeps
  // glitching in and out of lock still runs out of time.
  assign timeout = ((state_q == WAIT_LOCK) || (state_q == STABLE)) &&
                   (tmo_cnt == TMO_LAST);

  always_comb begin
    state_n   = state_q;
    rst_cnt_n = rst_cnt;
    tmo_cnt_n = tmo_cnt;
    stb_cnt_n = stb_cnt;
    retry_n   = retry_cnt;
    lost_n    = lost_cnt;
    loss_n    = 1'b0;

    if (restart) begin
      state_n   = PLL_RST;
      rst_cnt_n = '0;
      retry_n   = '0;
    end else if (timeout) begin
      // A timeout wins over a stable completion in the same cycle.
      if (retry_cnt == RTY_MAX) begin
        state_n = FAULT;
      end else begin
        state_n = PLL_RST;
        retry_n = retry_cnt + 1'b1;
      end
    end else begin
      case (state_q)
        PLL_RST: begin
          if (rst_cnt == RST_LAST) begin
            state_n   = WAIT_LOCK;
            rst_cnt_n = '0;
            tmo_cnt_n = '0;
          end else begin
            rst_cnt_n = rst_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          tmo_cnt_n = tmo_cnt + 1'b1;
          if (lock_s) begin
            state_n   = STABLE;
            stb_cnt_n = '0;
          end
        end
        STABLE: begin
          tmo_cnt_n = tmo_cnt + 1'b1;
          if (!lock_s) begin
            // Any dropout restarts qualification from scratch.
            state_n   = WAIT_LOCK;
            stb_cnt_n = '0;
          end else if (stb_cnt == STB_LAST) begin
            state_n = RUN;
            retry_n = '0;
          end else begin
            stb_cnt_n = stb_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_n = PLL_RST;
            loss_n  = 1'b1;
            if (lost_cnt != '1) lost_n = lost_cnt + 1'b1;
          end
        end
        FAULT: begin
          // Held until restart or reset.
        end
        default: begin
          state_n   = PLL_RST;
          rst_cnt_n = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state and then registered, so they
    // change on the same edge as 'state' and are glitch-free.
    pll_rst_n = (state_n == PLL_RST) || (state_n == FAULT);
    sys_rst_n = (state_n != RUN);
    ready_n   = (state_n == RUN);
    fault_n   = (state_n == FAULT);
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q   <= PLL_RST;
      rst_cnt   <= '0;
      tmo_cnt   <= '0;
      stb_cnt   <= '0;
      retry_cnt <= '0;
      lost_cnt  <= '0;
      lock_loss <= 1'b0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      pll_ready <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_n;
      rst_cnt   <= rst_cnt_n;
      tmo_cnt   <= tmo_cnt_n;
      stb_cnt   <= stb_cnt_n;
      retry_cnt <= retry_n;
      lost_cnt  <= lost_n;
      lock_loss <= loss_n;
      pll_rst   <= pll_rst_n;
      sys_rst   <= sys_rst_n;
      pll_ready <= ready_n;
      fault     <= fault_n;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_usb_pd_pll_ctrl.sv
// Directed testbench for usb_pd_pll_ctrl with small timing parameters
// (RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2).
// Inputs are driven and outputs sampled on the falling edge of refclk.
// "After edge n" means after the n-th rising edge following reset release.
module tb_usb_pd_pll_ctrl;

  logic       refclk;
  logic       reset;
  logic       extlock;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       pll_ready;
  logic       fault;
  logic       lock_loss;
  logic [2:0] state;
  logic [7:0] lost_cnt;

  int         n_chk;
  int         n_bad;
  logic [7:0] exp_q[$];
  logic [7:0] exp_lost;
  logic [2:0] exp_st;
  logic       exp_pr;

  usb_pd_pll_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .LOCK_STABLE  (8),
    .MAX_RETRY    (2)
  ) dut (
    .refclk    (refclk),
    .reset     (reset),
    .extlock   (extlock),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .pll_ready (pll_ready),
    .fault     (fault),
    .lock_loss (lock_loss),
    .state     (state),
    .lost_cnt  (lost_cnt)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    refclk = 1'b0;
    forever #10 refclk = ~refclk;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: wait for the falling edge, then check the output invariants.
  task automatic tick();
    @(negedge refclk);
    chk("inv_fault_and_ready", 32'(fault & pll_ready), 0);
    chk("inv_ready_in_reset", 32'(pll_ready & (sys_rst | pll_rst)), 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    restart = 1'b0;
    extlock = 1'b0;
    ticks(2);
    reset   = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"},     32'(state), 0);
    chk({tag, "_pll_rst"},   32'(pll_rst), 1);
    chk({tag, "_sys_rst"},   32'(sys_rst), 1);
    chk({tag, "_pll_ready"}, 32'(pll_ready), 0);
    chk({tag, "_fault"},     32'(fault), 0);
    chk({tag, "_lock_loss"}, 32'(lock_loss), 0);
    chk({tag, "_lost_cnt"},  32'(lost_cnt), 0);
  endtask

  task automatic wait_state(input logic [2:0] exp, input int lim, input string tag);
    for (int i = 0; i < lim && state !== exp; i++) tick();
    chk(tag, 32'(state), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_chk   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    restart = 1'b0;
    extlock = 1'b0;

    // Reset values
    do_reset();
    check_reset_vals("rst");

    // Normal bring-up: extlock captured on edge 6
    ticks(3);
    chk("n_pll_rst_held", 32'(pll_rst), 1);
    tick();                                   // edge 4
    chk("n_pll_rst_release", 32'(pll_rst), 0);
    chk("n_wait_lock", 32'(state), 1);
    tick();                                   // edge 5
    extlock = 1'b1;
    ticks(10);                                // edge 15
    chk("n_still_stable", 32'(state), 2);
    chk("n_sys_rst_held", 32'(sys_rst), 1);
    chk("n_not_ready", 32'(pll_ready), 0);
    tick();                                   // edge 16
    chk("n_run", 32'(state), 3);
    chk("n_ready", 32'(pll_ready), 1);
    chk("n_sys_rst_rel", 32'(sys_rst), 0);
    chk("n_pll_rst_low", 32'(pll_rst), 0);

    // Lock loss in RUN: extlock low captured edge 17, lock_s low after 18
    extlock = 1'b0;
    ticks(2);                                 // edge 18
    chk("l_still_run", 32'(state), 3);
    chk("l_no_pulse_yet", 32'(lock_loss), 0);
    tick();                                   // edge 19
    chk("l_pulse", 32'(lock_loss), 1);
    chk("l_lost_cnt", 32'(lost_cnt), 1);
    chk("l_state", 32'(state), 0);
    chk("l_sys_rst", 32'(sys_rst), 1);
    chk("l_pll_rst", 32'(pll_rst), 1);
    tick();
    chk("l_single_pulse", 32'(lock_loss), 0);
    chk("l_lost_cnt_hold", 32'(lost_cnt), 1);

    // 256 further losses: counter saturates at 255
    exp_lost = 8'd1;
    for (int i = 0; i < 256; i++) begin
      extlock = 1'b1;
      wait_state(3'd3, 40, "s_reach_run");
      extlock = 1'b0;
      for (int k = 0; k < 6 && lock_loss !== 1'b1; k++) tick();
      chk("s_pulse", 32'(lock_loss), 1);
      exp_lost = (exp_lost == 8'd255) ? 8'd255 : exp_lost + 8'd1;
      exp_q.push_back(exp_lost);
      chk("s_lost_cnt", 32'(lost_cnt), 32'(exp_q.pop_front()));
      tick();
      chk("s_single_pulse", 32'(lock_loss), 0);
    end
    chk("s_saturated", 32'(lost_cnt), 255);

    // restart keeps lost_cnt; reset (with restart) mid-STABLE clears all
    extlock = 1'b1;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("r_state", 32'(state), 0);
    chk("r_lost_kept", 32'(lost_cnt), 255);
    wait_state(3'd2, 20, "r_reach_stable");
    reset   = 1'b1;
    restart = 1'b1;
    tick();
    reset   = 1'b0;
    restart = 1'b0;
    check_reset_vals("mid_stb");

    // Glitch: high edges 6..10, low edge 11, high from edge 12
    do_reset();
    ticks(5);
    extlock = 1'b1;
    ticks(5);                                 // edge 10
    extlock = 1'b0;
    tick();                                   // edge 11
    extlock = 1'b1;
    ticks(2);                                 // edge 13
    chk("g_back_to_wait", 32'(state), 1);
    for (int i = 14; i <= 21; i++) begin
      tick();
      chk("g_sys_rst_held", 32'(sys_rst), 1);
    end
    chk("g_stable", 32'(state), 2);
    tick();                                   // edge 22
    chk("g_run", 32'(state), 3);
    chk("g_sys_rst_rel", 32'(sys_rst), 0);

    // restart on the same edge as stable completion (edge 16)
    do_reset();
    ticks(5);
    extlock = 1'b1;
    ticks(10);
    restart = 1'b1;
    tick();                                   // edge 16
    restart = 1'b0;
    chk("sc_state", 32'(state), 0);
    chk("sc_not_ready", 32'(pll_ready), 0);
    chk("sc_sys_rst", 32'(sys_rst), 1);
    ticks(12);                                // edge 28
    chk("sc_stable_again", 32'(state), 2);
    tick();                                   // edge 29
    chk("sc_run_again", 32'(state), 3);

    // restart on the same edge as the first timeout (edge 24): retry stays 0,
    // so FAULT needs three full attempts, reached at edge 24+72
    do_reset();
    ticks(23);
    chk("st_waiting", 32'(state), 1);
    restart = 1'b1;
    tick();                                   // edge 24
    restart = 1'b0;
    chk("st_state", 32'(state), 0);
    ticks(71);                                // edge 95
    chk("st_no_early_fault", 32'(state), 1);
    tick();                                   // edge 96
    chk("st_fault", 32'(state), 4);

    // Timeout / retry: 3 attempts of 4 + 20 cycles, then FAULT at edge 72
    do_reset();
    for (int n = 1; n <= 72; n++) begin
      tick();
      exp_st = (n >= 72) ? 3'd4 : (((n % 24) < 4) ? 3'd0 : 3'd1);
      exp_pr = (n >= 72) || ((n % 24) < 4);
      chk("tr_state", 32'(state), 32'(exp_st));
      chk("tr_pll_rst", 32'(pll_rst), 32'(exp_pr));
    end
    chk("tr_fault", 32'(fault), 1);
    chk("tr_sys_rst", 32'(sys_rst), 1);
    ticks(8);                                 // edge 80
    chk("tr_fault_held", 32'(state), 4);
    restart = 1'b1;
    tick();                                   // edge 81
    restart = 1'b0;
    chk("tr_restart_state", 32'(state), 0);
    chk("tr_restart_fault", 32'(fault), 0);
    chk("tr_restart_pll_rst", 32'(pll_rst), 1);
    ticks(71);                                // edge 152
    chk("tr_retry_cleared", 32'(state), 1);
    tick();                                   // edge 153
    chk("tr_fault_again", 32'(state), 4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
